// File: rtl/mcycle_unit_if.sv
// mcycle_unit_if: request/result bundle between the E-stage decode logic and the
// iterative multiply/divide unit.
//   Start     request from the E-stage instruction, held while it is stalled
//   MCycleOp  bit1: 0 = multiply, 1 = divide; bit0: 0 = signed, 1 = unsigned
//   Operand1  multiplicand / dividend
//   Operand2  multiplier / divisor
//   Result1   product low word / quotient
//   Result2   product high word / remainder
//   Busy      operation in progress (stall request to the hazard unit)
// master: the requester (pipeline); slave: the execution unit.
interface mcycle_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  modport master (
    output Start,
    output MCycleOp,
    output Operand1,
    output Operand2,
    input  Result1,
    input  Result2,
    input  Busy
  );

  modport slave (
    input  Start,
    input  MCycleOp,
    input  Operand1,
    input  Operand2,
    output Result1,
    output Result2,
    output Busy
  );
endinterface

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multiply/divide unit for the Execute stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle over
// a 2*WIDTH register; operands are latched as magnitudes and the sign is fixed up
// when the result registers are loaded.
//   CLK    rising-edge clock
//   RESET  synchronous, active-high; aborts any operation and clears results
//   bus    mcycle_unit_if slave modport (Start/MCycleOp/Operand1/Operand2 in,
//          Result1/Result2/Busy out)
// Busy is high from the cycle Start is first seen for WIDTH+1 cycles; results are
// valid from the following cycle and hold until the next operation completes.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  mcycle_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StComputing,
    StDone
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] counter_q, counter_d;
  logic busy;

  // Latched operation context
  logic               is_div_q;
  logic               neg_main_q;  // product / quotient must be negated
  logic               neg_rem_q;   // remainder must be negated (dividend sign)
  logic               div_zero_q;
  logic [WIDTH-1:0]   raw_op1_q;   // dividend as presented, for divide-by-zero
  logic [WIDTH-1:0]   addend_q;    // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   result1_q, result2_q;

  // Operand decode at the start of an operation
  logic             op_signed;
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    op_signed = ~bus.MCycleOp[0];
    op1_neg   = op_signed & bus.Operand1[WIDTH-1];
    op2_neg   = op_signed & bus.Operand2[WIDTH-1];
    mag1      = op1_neg ? (~bus.Operand1 + 1'b1) : bus.Operand1;
    mag2      = op2_neg ? (~bus.Operand2 + 1'b1) : bus.Operand2;
  end

  // One iteration step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_hi;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    // Multiply: multiplier sits in the low half and is consumed LSB first; the
    // carry out of the upper-half add is shifted back in at the top.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, addend_q} : {(WIDTH + 1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: shift the partial remainder left by one, bringing in the next
    // dividend bit, and subtract the divisor when it fits. Quotient bits fill
    // the low half from the right.
    div_hi   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_hi >= {1'b0, addend_q});
    div_diff = div_hi - {1'b0, addend_q};
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_hi[WIDTH-1:0]),
                acc_q[WIDTH-2:0], div_ge};

    acc_next = is_div_q ? div_next : mul_next;
  end

  // Sign correction of the final iteration's value
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   res1_fin, res2_fin;

  always_comb begin
    prod_fix = neg_main_q ? (~acc_next + 1'b1) : acc_next;
    quot_fix = neg_main_q ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) :
                           acc_next[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      res1_fin = prod_fix[WIDTH-1:0];
      res2_fin = prod_fix[2*WIDTH-1:WIDTH];
    end else if (div_zero_q) begin
      res1_fin = {WIDTH{1'b1}};
      res2_fin = raw_op1_q;
    end else begin
      // Most-negative / -1 needs no special case: the magnitude quotient is
      // 2^(WIDTH-1), whose negation is itself, with a zero remainder.
      res1_fin = quot_fix;
      res2_fin = rem_fix;
    end
  end

  // FSM next state and Busy
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Combinational so the stall lands in the same cycle Start appears
        busy = bus.Start;
        if (bus.Start) begin
          state_d   = StComputing;
          counter_d = '0;
        end
      end
      StComputing: begin
        busy      = 1'b1;
        counter_d = counter_q + 1'b1;
        if (counter_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Start here still belongs to the finishing instruction
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      raw_op1_q  <= '0;
      addend_q   <= '0;
      acc_q      <= '0;
      result1_q  <= '0;
      result2_q  <= '0;
    end else if (state_q == StIdle && bus.Start) begin
      is_div_q   <= bus.MCycleOp[1];
      neg_main_q <= op1_neg ^ op2_neg;
      neg_rem_q  <= op1_neg;
      div_zero_q <= (bus.Operand2 == '0);
      raw_op1_q  <= bus.Operand1;
      if (bus.MCycleOp[1]) begin
        addend_q <= mag2;
        acc_q    <= {{WIDTH{1'b0}}, mag1};
      end else begin
        addend_q <= mag1;
        acc_q    <= {{WIDTH{1'b0}}, mag2};
      end
    end else if (state_q == StComputing) begin
      acc_q <= acc_next;
      // Results load only on the last step, so they are valid in the DONE cycle
      // and never expose intermediate values.
      if (counter_q == LastCnt) begin
        result1_q <= res1_fin;
        result2_q <= res2_fin;
      end
    end
  end

  assign bus.Busy    = busy;
  assign bus.Result1 = result1_q;
  assign bus.Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Testbench for mcycle_unit: directed operations with hand-computed results feed
// a scoreboard queue; a monitor measures each Busy window and compares results
// when Busy falls, and checks that results stay stable at all other times.
module tb_mcycle_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mcycle_unit_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    int           len;
    int           id;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] held1 = '0;
  logic [W-1:0] held2 = '0;
  int           busy_len = 0;
  int           next_id = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      busy_len = 0;
      held1    = '0;
      held2    = '0;
    end else if (bus.Busy === 1'b1) begin
      busy_len++;
      check("hold_r1_busy", bus.Result1, held1);
      check("hold_r2_busy", bus.Result2, held2);
    end else if (busy_len > 0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: busy for %0d cycles, expected no operation",
                 busy_len);
      end else begin
        e = sb.pop_front();
        $display("op %0d: r1=%h r2=%h busy=%0d", e.id, bus.Result1, bus.Result2, busy_len);
        check("result1", bus.Result1, e.r1);
        check("result2", bus.Result2, e.r2);
        check("busy_len", W'(busy_len), W'(e.len));
        held1 = e.r1;
        held2 = e.r2;
      end
      busy_len = 0;
    end else begin
      check("hold_r1_idle", bus.Result1, held1);
      check("hold_r2_idle", bus.Result2, held2);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
    end
  endtask

  // Issues one operation and keeps Start high until the DONE cycle is reached;
  // the port operands are scrambled after the first edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r1,
                        input logic [W-1:0] r2);
    bit done;
    @(posedge clk);
    #1;
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    sb.push_back('{r1: r1, r2: r2, len: int'(W) + 1, id: next_id});
    next_id++;
    #1;
    check("busy_comb", W'(bus.Busy), W'(1));
    @(posedge clk);
    #1;
    bus.Operand1 = $urandom;
    bus.Operand2 = $urandom;
    bus.MCycleOp = ~op;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.Busy !== 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still %b after 200 cycles, expected low", bus.Busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", W'(bus.Busy), W'(0));
    check("reset_r1", bus.Result1, 32'h0);
    check("reset_r2", bus.Result2, 32'h0);

    // Unsigned multiply
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001);
    idle(3);
    // Signed multiply -3 * 5
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
    idle(2);
    // Signed divide -7 / 2, then back-to-back unsigned 100 / 7
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2);
    idle(2);
    // Divide by zero, then signed overflow
    run_op(2'b11, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
    idle(1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    // Start held through DONE only: no second window expected
    idle(5);
    // Further corner cases
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000);
    idle(1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    idle(1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    idle(1);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    idle(1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    idle(2);

    // Reset in cycle 10 of an operation: nothing is pushed for the aborted op
    @(posedge clk);
    #1;
    bus.Start    = 1'b1;
    bus.MCycleOp = 2'b01;
    bus.Operand1 = 32'h0000_0003;
    bus.Operand2 = 32'h0000_0003;
    repeat (9) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.Start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(bus.Busy), W'(0));
    check("abort_r1", bus.Result1, 32'h0);
    check("abort_r2", bus.Result2, 32'h0);
    idle(2);
    run_op(2'b01, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 32'h0000_0001);
    idle(4);

    check("sb_drained", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
